pulse_rate_counter: RTL and testbench
=====================================

Name: pulse_rate_counter

Overview:
Parametrised rate divider plus wrap-around display counter. It produces a one-cycle enable pulse (Tick) at a selectable period and advances a COUNT_WIDTH counter on each Tick. The counter supports up/down counting, pause, and synchronous load. It feeds the hex display path on the board top level; CounterValue drives the hex decoder directly.

Parameters:
CLOCK_FREQUENCY, 50000000, Clock cycles per second; base period unit.
SPEED_BITS, 2, width of Speed select; 2**SPEED_BITS rate settings.
COUNT_WIDTH, 4, width of CounterValue.
MAX_COUNT, 15, terminal value; counter range is 0..MAX_COUNT; must be less than 2**COUNT_WIDTH.

Ports:
Clock  input  1  system clock.
Reset  input  1  synchronous, active-high reset.
Speed  input  SPEED_BITS  rate select: 0 gives period 1 cycle; k>0 gives period CLOCK_FREQUENCY<<(k-1) cycles.
Run  input  1  1 = divider counts; 0 = pause (divider and counter hold).
Dir  input  1  1 = count up, 0 = count down.
Load  input  1  synchronous load strobe.
LoadValue  input  COUNT_WIDTH  value loaded on Load.
Tick  output  1  one-cycle enable pulse at the selected period.
CounterValue  output  COUNT_WIDTH  current count.
Wrap  output  1  high in a Tick cycle whose advance wraps the counter.

Behaviour:
- Reset (synchronous, active-high; Reset Reset, clock Clock). Highest priority over all other inputs.
  - CounterValue = 0, Tick = 0, Wrap = 0.
  - Divider is loaded with period(Speed) - 1 and active period latches Speed.
- Divider: down-counter, width $clog2(max period).
  - Tick is combinational: Tick = (div == 0) && Run && !Reset.
  - On Tick, the divider reloads period(active speed) - 1.
  - Otherwise, when Run = 1, div decrements.
  - When Run = 0, div holds, and Tick and Wrap stay 0.
- Speed sampling: Speed is latched into the active period only at reset and on each Tick. A Speed change mid-period does not alter the current period.
- Speed 0 (period 1): div is always 0, so Tick = Run every cycle.
- First Tick: with Run held high from the first cycle after Reset deasserts, Tick asserts in cycle P, where P = period.
- Counter update: CounterValue changes at the clock edge that ends a Tick cycle (latency 1 from Tick).
  - Up: MAX_COUNT -> 0.
  - Down: 0 -> MAX_COUNT.
  - All other values step by +1 or -1.
- Wrap = Tick && ((Dir && CounterValue == MAX_COUNT) || (!Dir && CounterValue == 0)).
- Load (priority below Reset, above Tick):
  - CounterValue <= min(LoadValue, MAX_COUNT).
  - The divider restarts with period(Speed) - 1 and latches Speed.
  - If Tick coincides with Load, the Load value wins and no increment occurs. Tick still pulses in that cycle; Wrap = 0.
- Dir is sampled only in Tick cycles. Changing Dir between ticks has no other effect.
- Arithmetic is unsigned. Period computation uses a width wide enough for CLOCK_FREQUENCY<<(2**SPEED_BITS-2) with no overflow.

Optional Feature:
Macro PULSE_RATE_COUNTER_IMMEDIATE_SPEED_EN.
- Defined: a registered compare detects Speed != active speed in any non-Tick cycle. The next cycle, the divider reloads period(Speed) - 1 and latches Speed, so the new rate applies within 1 cycle. That cycle has no Tick.
- Undefined: Speed takes effect only at the next Tick, Load, or Reset, as above.

Test Plan:
All scenarios use CLOCK_FREQUENCY=4, so periods are 1/4/8/16.
1. Reset 2 cycles, then Speed=0, Run=1, Dir=1 -> Tick high every cycle. CounterValue steps 0,1,...,15,0. Wrap=1 only in the cycle CounterValue=15.
2. Speed=1, Run=1 from reset -> Tick in cycles 4,8,12,... CounterValue=8 after cycle 32. Tick is never high in 2 consecutive cycles.
3. Speed=1, switch to 3 at cycle 2 after a Tick:
   - Macro undefined -> next Tick after 2 more cycles, then every 16.
   - Macro defined -> next Tick 17 cycles after the change.
4. Speed=2, Run=0 for 10 cycles starting 3 cycles into a period -> no Tick during the pause. The next Tick arrives 5 cycles after Run returns to 1. CounterValue is unchanged across the pause.
5. Dir=0 from reset, Speed=0 -> first Tick has Wrap=1, and CounterValue becomes 15 then 14.
6. Load=1 with LoadValue=9 in a Tick cycle -> CounterValue=9 next cycle, Wrap=0. With MAX_COUNT=9, LoadValue=12 -> 9. Reset asserted together with Load mid-period -> CounterValue=0, Tick=0.

Source files
------------

// File: rtl/pulse_rate_counter.sv
// pulse_rate_counter: rate divider that emits a one-cycle Tick and a wrap-around up/down display counter.
// Define PULSE_RATE_COUNTER_IMMEDIATE_SPEED_EN to apply Speed changes within one cycle instead of at the next Tick.
module pulse_rate_counter #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int SPEED_BITS      = 2,
    parameter int COUNT_WIDTH     = 4,
    parameter int MAX_COUNT       = 15
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [SPEED_BITS-1:0]  Speed,
    input  logic                   Run,
    input  logic                   Dir,
    input  logic                   Load,
    input  logic [COUNT_WIDTH-1:0] LoadValue,
    output logic                   Tick,
    output logic [COUNT_WIDTH-1:0] CounterValue,
    output logic                   Wrap
);
    localparam longint MAX_PERIOD = longint'(CLOCK_FREQUENCY) << (2**SPEED_BITS - 2);
    localparam int PERIOD_W = $clog2(MAX_PERIOD + 1);
    localparam int DIV_W = (MAX_PERIOD > 1) ? $clog2(MAX_PERIOD) : 1;
    localparam logic [PERIOD_W-1:0] BASE_PERIOD = PERIOD_W'(CLOCK_FREQUENCY);
    localparam logic [COUNT_WIDTH-1:0] MAX_VAL = COUNT_WIDTH'(MAX_COUNT);

    // Divider reload value for a rate select: period - 1.
    function automatic logic [DIV_W-1:0] reload_of(input logic [SPEED_BITS-1:0] s);
        logic [PERIOD_W-1:0] p;
        p = (s == '0) ? PERIOD_W'(1) : BASE_PERIOD << (s - 1'b1);
        return DIV_W'(p - 1'b1);
    endfunction

    logic [DIV_W-1:0]       r_div;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [DIV_W-1:0]       w_reload;
    logic [COUNT_WIDTH-1:0] w_step;
    logic [COUNT_WIDTH-1:0] w_load_val;
    logic                   w_tick;
    logic                   w_at_end;
    logic                   w_restart;

`ifdef PULSE_RATE_COUNTER_IMMEDIATE_SPEED_EN
    logic [SPEED_BITS-1:0] r_speed;
    logic                  r_speed_chg;

    assign w_tick    = (r_div == '0) && Run && !Reset && !r_speed_chg;
    assign w_restart = Reset || Load || w_tick || r_speed_chg;

    // A pending speed change consumes one cycle to reload, so it never re-triggers on itself.
    always_ff @(posedge Clock) begin
        if (w_restart)
            r_speed <= Speed;
        r_speed_chg <= !w_restart && (Speed != r_speed);
    end
`else
    assign w_tick    = (r_div == '0) && Run && !Reset;
    assign w_restart = Reset || Load || w_tick;
`endif

    always_comb begin
        w_reload   = reload_of(Speed);
        w_at_end   = Dir ? (r_count == MAX_VAL) : (r_count == '0);
        w_step     = Dir ? (w_at_end ? '0 : r_count + 1'b1)
                         : (w_at_end ? MAX_VAL : r_count - 1'b1);
        w_load_val = (LoadValue > MAX_VAL) ? MAX_VAL : LoadValue;
    end

    always_ff @(posedge Clock) begin
        if (w_restart)
            r_div <= w_reload;
        else if (Run)
            r_div <= r_div - 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (Reset)
            r_count <= '0;
        else if (Load)
            r_count <= w_load_val;
        else if (w_tick)
            r_count <= w_step;
    end

    assign Tick         = w_tick;
    assign Wrap         = w_tick && !Load && w_at_end;
    assign CounterValue = r_count;
endmodule

// File: tb/tb_pulse_rate_counter.sv
// tb_pulse_rate_counter: directed scenarios with a tick scoreboard checked by an independent monitor.
module tb_pulse_rate_counter;
    typedef struct {
        int         cyc;
        logic [3:0] cnt;
        logic       wrap;
    } exp_t;

    logic       Clock = 1'b0;
    logic       Reset, Run, Dir, Load;
    logic [1:0] Speed;
    logic [3:0] LoadValue, CounterValue;
    logic       Tick, Wrap;
    logic       c_Reset, c_Run, c_Dir, c_Load;
    logic [1:0] c_Speed;
    logic [3:0] c_LoadValue, c_CounterValue;
    logic       c_Tick, c_Wrap;

    exp_t q[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   base = 0;

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    pulse_rate_counter #(.CLOCK_FREQUENCY(4), .SPEED_BITS(2), .COUNT_WIDTH(4), .MAX_COUNT(15)) u_dut (
        .Clock(Clock), .Reset(Reset), .Speed(Speed), .Run(Run), .Dir(Dir), .Load(Load),
        .LoadValue(LoadValue), .Tick(Tick), .CounterValue(CounterValue), .Wrap(Wrap)
    );

    pulse_rate_counter #(.CLOCK_FREQUENCY(4), .SPEED_BITS(2), .COUNT_WIDTH(4), .MAX_COUNT(9)) u_clamp (
        .Clock(Clock), .Reset(c_Reset), .Speed(c_Speed), .Run(c_Run), .Dir(c_Dir), .Load(c_Load),
        .LoadValue(c_LoadValue), .Tick(c_Tick), .CounterValue(c_CounterValue), .Wrap(c_Wrap)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - base + 1);
        end
    endtask

    // k is the 1-based cycle number counted from reset release.
    task automatic push(input int k, input int c, input logic w);
        exp_t e;
        e.cyc  = base + k - 1;
        e.cnt  = 4'(c);
        e.wrap = w;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic do_reset;
        Reset = 1'b1;
        Load  = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        chk("reset_count", CounterValue, 0);
        chk("reset_tick", Tick, 0);
        chk("reset_wrap", Wrap, 0);
        @(posedge Clock);
        #1 Reset = 1'b0;
        base = cyc;
    endtask

    always @(negedge Clock) begin
        if (Tick === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_tick: tick at cycle %0d count %0d, none required", cyc - base + 1, CounterValue);
            end else begin
                m_e = q.pop_front();
                chk("tick_cycle", cyc, m_e.cyc);
                chk("tick_count", CounterValue, m_e.cnt);
                chk("tick_wrap", Wrap, m_e.wrap);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1; Speed = 2'd0; Run = 1'b0; Dir = 1'b1; Load = 1'b0; LoadValue = 4'd0;
        c_Reset = 1'b1; c_Speed = 2'd0; c_Run = 1'b0; c_Dir = 1'b1; c_Load = 1'b0; c_LoadValue = 4'd0;

        // Speed 0: tick every cycle, full up-count with wrap at 15.
        Speed = 2'd0; Run = 1'b1; Dir = 1'b1;
        do_reset;
        for (int i = 0; i < 17; i++) push(i + 1, i % 16, i == 15);
        step(17);
        Run = 1'b0;
        @(negedge Clock);
        chk("speed0_final", CounterValue, 1);

        // Speed 1: period 4, eight ticks by cycle 32.
        Speed = 2'd1; Run = 1'b1;
        do_reset;
        for (int j = 1; j <= 8; j++) push(4 * j, j - 1, 1'b0);
        step(32);
        Run = 1'b0;
        @(negedge Clock);
        chk("speed1_after32", CounterValue, 8);

        // Speed change mid-period.
        Speed = 2'd1; Run = 1'b1;
        do_reset;
        push(4, 0, 1'b0);
`ifdef PULSE_RATE_COUNTER_IMMEDIATE_SPEED_EN
        push(23, 1, 1'b0);
        push(39, 2, 1'b0);
`else
        push(8, 1, 1'b0);
        push(24, 2, 1'b0);
        push(40, 3, 1'b0);
`endif
        step(5);
        Speed = 2'd3;
        step(35);
        Run = 1'b0;

        // Pause 3 cycles into a period of 8.
        Speed = 2'd2; Run = 1'b1;
        do_reset;
        push(8, 0, 1'b0);
        push(26, 1, 1'b0);
        step(11);
        Run = 1'b0;
        @(negedge Clock);
        chk("pause_hold_start", CounterValue, 1);
        repeat (9) @(posedge Clock);
        @(negedge Clock);
        chk("pause_hold_end", CounterValue, 1);
        @(posedge Clock);
        #1 Run = 1'b1;
        step(5);
        Run = 1'b0;

        // Down count from reset wraps to 15 first.
        Speed = 2'd0; Dir = 1'b0; Run = 1'b1;
        do_reset;
        push(1, 0, 1'b1);
        push(2, 15, 1'b0);
        push(3, 14, 1'b0);
        step(3);
        Run = 1'b0;
        @(negedge Clock);
        chk("down_final", CounterValue, 13);

        // Load coinciding with a would-be wrapping tick.
        Speed = 2'd1; Dir = 1'b0; Run = 1'b1;
        do_reset;
        push(4, 0, 1'b0);
        push(8, 9, 1'b0);
        step(3);
        Load = 1'b1; LoadValue = 4'd9;
        step(1);
        Load = 1'b0;
        @(negedge Clock);
        chk("load_on_tick", CounterValue, 9);
        step(4);
        Run = 1'b0;

        // Reset together with Load in a cycle where the divider has expired.
        Speed = 2'd1; Dir = 1'b1; Run = 1'b1;
        do_reset;
        step(3);
        Reset = 1'b1; Load = 1'b1; LoadValue = 4'd5;
        @(negedge Clock);
        chk("reset_load_tick", Tick, 0);
        chk("reset_load_wrap", Wrap, 0);
        @(posedge Clock);
        #1 Reset = 1'b0; Load = 1'b0;
        base = cyc;
        push(4, 0, 1'b0);
        @(negedge Clock);
        chk("reset_load_count", CounterValue, 0);
        step(4);
        Run = 1'b0;

        // MAX_COUNT=9 instance: load clamping and wrap at 9.
        @(posedge Clock);
        #1 c_Reset = 1'b0; c_Load = 1'b1; c_LoadValue = 4'd7;
        @(posedge Clock);
        #1 c_LoadValue = 4'd12;
        @(negedge Clock);
        chk("clamp_pass", c_CounterValue, 7);
        @(posedge Clock);
        #1 c_Load = 1'b0; c_Run = 1'b1;
        @(negedge Clock);
        chk("clamp_sat", c_CounterValue, 9);
        chk("clamp_tick", c_Tick, 1);
        chk("clamp_wrap", c_Wrap, 1);
        @(posedge Clock);
        #1 c_Run = 1'b0;
        @(negedge Clock);
        chk("clamp_wrapped", c_CounterValue, 0);

        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
